// File: rtl/bcd_display_scan.sv
// Multiplexed seven-segment driver: snapshots a packed BCD vector once per frame and
// scans one digit at a time onto a shared segment bus with optional leading-zero blanking.
module bcd_display_scan #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic                  blank_lz,
  input  logic                  hold,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  err,
  output logic                  frame_done
);

  localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

  logic [PreW-1:0]       pre_q, pre_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic                  first_q, first_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  err_q, err_d;
  logic                  frame_done_q, frame_done_d;

  logic                  pre_last, idx_last, wrap;
  logic [DIGITS-1:0]     zero_from;
  logic                  zero_run;
  logic [3:0]            cur_nib;
  logic                  cur_zero_from;
  logic                  cur_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Scan position and snapshot update.
  always_comb begin
    pre_last = (pre_q == PreLast);
    idx_last = (idx_q == IdxLast);
    wrap     = pre_last && idx_last;

    pre_d = pre_last ? '0 : pre_q + PreW'(1);
    idx_d = idx_q;
    if (pre_last) begin
      idx_d = idx_last ? '0 : idx_q + IdxW'(1);
    end

    shadow_d = (first_q || (wrap && !hold)) ? digits : shadow_q;
    first_d  = 1'b0;
  end

  // zero_from[i]: shadow digits i..DIGITS-1 are all zero (invalid nibbles count as non-zero).
  always_comb begin
    zero_from = '0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (shadow_q[4*i +: 4] == 4'd0);
      zero_from[i] = zero_run;
    end
  end

  // Output register inputs, taken from the pre-edge index and snapshot.
  always_comb begin
    an_d          = '0;
    cur_nib       = 4'd0;
    cur_zero_from = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        an_d[i]       = 1'b1;
        cur_nib       = shadow_q[4*i +: 4];
        cur_zero_from = zero_from[i];
      end
    end

    cur_blank    = blank_lz && (idx_q != '0) && cur_zero_from;
    seg_d        = cur_blank ? 7'h00 : seg_decode(cur_nib);
    err_d        = !cur_blank && (cur_nib > 4'd9);
    frame_done_d = wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      first_q      <= 1'b1;
      an_q         <= '0;
      seg_q        <= 7'h00;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      first_q      <= first_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign err        = err_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan: a cycle model feeds a scoreboard queue that is
// checked every cycle, plus fixed-value checks at the interesting scan points.
module tb_bcd_display_scan;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       err;
    logic       fd;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [15:0] digits;
  logic        blank_lz;
  logic        hold;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        err;
  logic        frame_done;

  logic        rst1;
  logic [3:0]  digits1;
  logic        blank1;
  logic        hold1;
  logic [0:0]  an1;
  logic [6:0]  seg1;
  logic        err1;
  logic        fd1;

  int          checks;
  int          failures;
  exp_t        sb[$];
  logic [6:0]  q2[$];
  logic [6:0]  seg_tab [16];

  int          m_pre;
  int          m_idx;
  logic [15:0] m_shadow;
  bit          m_first;
  bit          live_on;
  int          cnt;

  bcd_display_scan #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .digits     (digits),
    .blank_lz   (blank_lz),
    .hold       (hold),
    .an         (an),
    .seg        (seg),
    .err        (err),
    .frame_done (frame_done)
  );

  bcd_display_scan #(.DIGITS(1), .SCAN_DIV(1)) dut1 (
    .clk        (clk),
    .reset      (rst1),
    .digits     (digits1),
    .blank_lz   (blank1),
    .hold       (hold1),
    .an         (an1),
    .seg        (seg1),
    .err        (err1),
    .frame_done (fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pre    = 0;
    m_idx    = 0;
    m_shadow = 16'h0;
    m_first  = 1'b1;
  endtask

  // Behavioural model of one rising edge; pushes the outputs expected after it.
  task automatic model_step();
    exp_t       e;
    logic [3:0] nib;
    int         msd;
    bit         blank;
    if (reset) begin
      model_reset();
      sb.push_back('0);
      return;
    end
    nib = m_shadow[m_idx*4 +: 4];
    msd = -1;
    for (int i = 0; i < 4; i++) begin
      if (m_shadow[i*4 +: 4] != 4'd0) msd = i;
    end
    blank = blank_lz && (m_idx != 0) && (m_idx > msd);
    e.an  = 4'b0001 << m_idx;
    e.seg = blank ? 7'h00 : seg_tab[nib];
    e.err = !blank && (nib > 4'd9);
    e.fd  = (m_pre == 3) && (m_idx == 3);
    if (m_first || (e.fd && !hold)) m_shadow = digits;
    m_first = 1'b0;
    m_pre++;
    if (m_pre == 4) begin
      m_pre = 0;
      m_idx = (m_idx + 1) % 4;
    end
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_step();
    if (live_on) q2.push_back(seg_tab[digits1]);
    @(negedge clk);
    chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("an", {28'd0, an}, {28'd0, e.an});
      chk("seg", {25'd0, seg}, {25'd0, e.seg});
      chk("err", {31'd0, err}, {31'd0, e.err});
      chk("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
    end
    if (live_on) begin
      chk("live_seg", {25'd0, seg1}, {25'd0, q2.pop_front()});
      chk("live_err", {31'd0, err1}, 32'd0);
      chk("live_an", {31'd0, an1}, 32'd1);
      cnt     = (cnt == 9) ? 0 : cnt + 1;
      digits1 = cnt[3:0];
    end
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    checks = 0; failures = 0;
    digits = 16'h1234; blank_lz = 1'b0; hold = 1'b0;
    reset = 1'b0; rst1 = 1'b0; digits1 = 4'd0; blank1 = 1'b0; hold1 = 1'b0;
    live_on = 1'b0; cnt = 0;
    model_reset();
    #1 reset = 1'b1; rst1 = 1'b1;
    #2;
    chk("rst_an", {28'd0, an}, 32'd0);
    chk("rst_seg", {25'd0, seg}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    tick(); tick();
    reset = 1'b0;

    // Basic scan of 1234
    tick();            chk("e1_an", {28'd0, an}, 32'h1); chk("e1_seg", {25'd0, seg}, 32'h3F);
    tick();            chk("e2_an", {28'd0, an}, 32'h1); chk("e2_seg", {25'd0, seg}, 32'h66);
    repeat (3) tick(); chk("e5_an", {28'd0, an}, 32'h2); chk("e5_seg", {25'd0, seg}, 32'h4F);
    repeat (4) tick(); chk("e9_an", {28'd0, an}, 32'h4); chk("e9_seg", {25'd0, seg}, 32'h5B);
    repeat (4) tick(); chk("e13_an", {28'd0, an}, 32'h8); chk("e13_seg", {25'd0, seg}, 32'h06);
    repeat (3) tick(); chk("e16_fd", {31'd0, frame_done}, 32'd1);
    tick();            chk("e17_an", {28'd0, an}, 32'h1); chk("e17_fd", {31'd0, frame_done}, 32'd0);

    // Mid-frame change is invisible until the next wrap
    repeat (3) tick();
    digits = 16'h5678;
    repeat (11) tick(); chk("e31_seg_old", {25'd0, seg}, 32'h06);
    tick();             chk("e32_fd", {31'd0, frame_done}, 32'd1);
    tick();             chk("e33_seg_new", {25'd0, seg}, 32'h7F);

    // Hold across a wrap keeps 5678, frame_done still pulses
    hold = 1'b1; digits = 16'h1234;
    repeat (15) tick(); chk("e48_fd_hold", {31'd0, frame_done}, 32'd1);
    tick();             chk("e49_seg_held", {25'd0, seg}, 32'h7F);

    // Leading-zero blanking
    hold = 1'b0; blank_lz = 1'b1; digits = 16'h0070;
    repeat (15) tick();
    tick();            chk("b0_seg", {25'd0, seg}, 32'h3F);
    repeat (4) tick(); chk("b1_seg", {25'd0, seg}, 32'h07);
    repeat (4) tick(); chk("b2_seg", {25'd0, seg}, 32'h00); chk("b2_an", {28'd0, an}, 32'h4);
    repeat (4) tick(); chk("b3_seg", {25'd0, seg}, 32'h00);
    digits = 16'h0000;
    repeat (3) tick();
    tick();            chk("z0_seg", {25'd0, seg}, 32'h3F);
    repeat (4) tick(); chk("z1_seg", {25'd0, seg}, 32'h00); chk("z1_an", {28'd0, an}, 32'h2);

    // Invalid nibble stops blanking below it
    digits = 16'h00A5;
    repeat (11) tick();
    tick();            chk("i0_seg", {25'd0, seg}, 32'h6D); chk("i0_err", {31'd0, err}, 32'd0);
    repeat (4) tick(); chk("i1_seg", {25'd0, seg}, 32'h40); chk("i1_err", {31'd0, err}, 32'd1);
    repeat (3) tick(); chk("i1_err_end", {31'd0, err}, 32'd1);
    tick();            chk("i2_seg", {25'd0, seg}, 32'h00); chk("i2_err", {31'd0, err}, 32'd0);

    // Asynchronous reset while digit 2 is enabled
    reset = 1'b1;
    #1;
    chk("mrst_an", {28'd0, an}, 32'd0);
    chk("mrst_seg", {25'd0, seg}, 32'd0);
    chk("mrst_err", {31'd0, err}, 32'd0);
    chk("mrst_fd", {31'd0, frame_done}, 32'd0);
    model_reset();
    tick();
    reset = 1'b0;
    tick();            chk("r1_an", {28'd0, an}, 32'h1); chk("r1_seg", {25'd0, seg}, 32'h3F);
    tick();            chk("r2_seg", {25'd0, seg}, 32'h6D);
    repeat (2) tick(); chk("r4_an", {28'd0, an}, 32'h1);
    tick();            chk("r5_an", {28'd0, an}, 32'h2);

    // Live BCD counter into a 1-digit, 1-cycle-dwell instance
    rst1 = 1'b0; digits1 = 4'd0; cnt = 0;
    q2.delete();
    q2.push_back(7'h3F);
    live_on = 1'b1;
    repeat (30) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
